// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32IM single-cycle datapath: opcodes, immediate
// formats, ALU operation codes and the built-in program image.
package rv32_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // PC space is 32 words; the mask folds PC+4 back to 0 after byte 124.
    localparam logic [31:0] PC_WRAP_MASK = 32'h0000_007F;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    // ALUselect = {isM, alt, funct3}
    localparam logic [4:0] ALU_ADD    = 5'b0_0_000;
    localparam logic [4:0] ALU_SLL    = 5'b0_0_001;
    localparam logic [4:0] ALU_SLT    = 5'b0_0_010;
    localparam logic [4:0] ALU_SLTU   = 5'b0_0_011;
    localparam logic [4:0] ALU_XOR    = 5'b0_0_100;
    localparam logic [4:0] ALU_SRL    = 5'b0_0_101;
    localparam logic [4:0] ALU_OR     = 5'b0_0_110;
    localparam logic [4:0] ALU_AND    = 5'b0_0_111;
    localparam logic [4:0] ALU_SUB    = 5'b0_1_000;
    localparam logic [4:0] ALU_SRA    = 5'b0_1_101;
    localparam logic [4:0] ALU_MUL    = 5'b1_0_000;
    localparam logic [4:0] ALU_MULH   = 5'b1_0_001;
    localparam logic [4:0] ALU_MULHSU = 5'b1_0_010;
    localparam logic [4:0] ALU_MULHU  = 5'b1_0_011;
    localparam logic [4:0] ALU_DIV    = 5'b1_0_100;
    localparam logic [4:0] ALU_DIVU   = 5'b1_0_101;
    localparam logic [4:0] ALU_REM    = 5'b1_0_110;
    localparam logic [4:0] ALU_REMU   = 5'b1_0_111;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic       regwen;
        imm_sel_e   imm_sel;
        logic       bsel;
    } ctrl_t;

    // Program image held in the instruction ROM; unlisted words are NOPs.
    function automatic logic [31:0] rom_word(input logic [4:0] addr);
        logic [31:0] w;
        case (addr)
            5'd0:    w = 32'h0050_0093;  // addi x1,x0,5
            5'd1:    w = 32'hFFD0_0113;  // addi x2,x0,-3
            5'd2:    w = 32'h0020_81B3;  // add  x3,x1,x2
            5'd3:    w = 32'h0220_8233;  // mul  x4,x1,x2
            5'd4:    w = 32'h0200_C2B3;  // div  x5,x1,x0
            5'd5:    w = 32'h4011_5313;  // srai x6,x2,1
            5'd6:    w = 32'h0070_0013;  // addi x0,x0,7
            5'd7:    w = 32'h0000_007F;  // unsupported opcode
            5'd8:    w = 32'h4020_83B3;  // sub  x7,x1,x2
            5'd9:    w = 32'h0220_9433;  // mulh x8,x1,x2
            5'd10:   w = 32'h0220_B4B3;  // mulhu x9,x1,x2
            5'd11:   w = 32'h0211_4533;  // div  x10,x2,x1
            5'd12:   w = 32'h0211_65B3;  // rem  x11,x2,x1
            5'd13:   w = 32'h0211_5633;  // divu x12,x2,x1
            5'd14:   w = 32'h0011_26B3;  // slt  x13,x2,x1
            5'd15:   w = 32'h0011_3733;  // sltu x14,x2,x1
            5'd16:   w = 32'h01C1_5793;  // srli x15,x2,28
            5'd17:   w = 32'h0040_9813;  // slli x16,x1,4
            5'd18:   w = 32'hFFF0_C893;  // xori x17,x1,-1
            5'd19:   w = 32'h4011_5933;  // sra  x18,x2,x1
            5'd20:   w = 32'h0200_F9B3;  // remu x19,x1,x0
            5'd21:   w = 32'h1234_5A37;  // lui  x20 (not executed)
            5'd22:   w = 32'h0020_FAB3;  // and  x21,x1,x2
            5'd23:   w = 32'h0020_EB33;  // or   x22,x1,x2
            5'd24:   w = 32'h0020_9BB3;  // sll  x23,x1,x2
            5'd25:   w = 32'h0211_2C33;  // mulhsu x24,x2,x1
            5'd26:   w = 32'h0010_0C93;  // addi x25,x0,1
            5'd27:   w = 32'h01FC_9C93;  // slli x25,x25,31
            5'd28:   w = 32'hFFF0_0D93;  // addi x27,x0,-1
            5'd29:   w = 32'h03BC_CD33;  // div  x26,x25,x27
            5'd30:   w = 32'h03BC_EE33;  // rem  x28,x25,x27
            default: w = NOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32IM ALU: base integer ops plus multiply, divide and
// remainder with RISC-V divide-by-zero and overflow results.
module alu
    import rv32_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  sel_i,
    output logic [31:0] y_o
);

    logic [4:0]  op;
    logic        alt_eff;
    logic [4:0]  shamt;
    logic        a_sgn, b_sgn;
    logic [63:0] a_ext, b_ext, prod;
    logic        div_sgn, a_neg, b_neg;
    logic [31:0] a_abs, b_abs, b_div, quo_u, rem_u, quo, rem;

    always_comb begin
        // alt only distinguishes SUB and SRA; elsewhere it is ignored
        alt_eff = sel_i[3] & ((sel_i[2:0] == 3'b000) | (sel_i[2:0] == 3'b101));
        op      = sel_i[4] ? {2'b10, sel_i[2:0]} : {1'b0, alt_eff, sel_i[2:0]};
        shamt   = b_i[4:0];

        // One 64-bit multiply; operand extension picks the signedness.
        a_sgn = (sel_i[1:0] != 2'b11);
        b_sgn = ~sel_i[1];
        a_ext = {{32{a_sgn & a_i[31]}}, a_i};
        b_ext = {{32{b_sgn & b_i[31]}}, b_i};
        prod  = a_ext * b_ext;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally.
        div_sgn = ~sel_i[0];
        a_neg   = div_sgn & a_i[31];
        b_neg   = div_sgn & b_i[31];
        a_abs   = a_neg ? (32'd0 - a_i) : a_i;
        b_abs   = b_neg ? (32'd0 - b_i) : b_i;
        b_div   = (b_i == 32'd0) ? 32'd1 : b_abs;
        quo_u   = a_abs / b_div;
        rem_u   = a_abs % b_div;
        quo     = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
        rem     = a_neg ? (32'd0 - rem_u) : rem_u;
        if (b_i == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = a_i;
        end

        case (op)
            ALU_ADD:    y_o = a_i + b_i;
            ALU_SUB:    y_o = a_i - b_i;
            ALU_SLL:    y_o = a_i << shamt;
            ALU_SLT:    y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:   y_o = {31'd0, a_i < b_i};
            ALU_XOR:    y_o = a_i ^ b_i;
            ALU_SRL:    y_o = a_i >> shamt;
            ALU_SRA:    y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     y_o = a_i | b_i;
            ALU_AND:    y_o = a_i & b_i;
            ALU_MUL:    y_o = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  y_o = prod[63:32];
            ALU_DIV,
            ALU_DIVU:   y_o = quo;
            ALU_REM,
            ALU_REMU:   y_o = rem;
            default:    y_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/control.sv
// Instruction decoder: OP and OP-IMM write back; everything else is a NOP.
module control
    import rv32_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       m_bit_i,    // funct7[0]
    input  logic       alt_bit_i,  // funct7[5]
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.imm_sel = IMM_I;
        case (opcode_i)
            OPC_OP: begin
                ctrl_o.alu_sel = {m_bit_i, alt_bit_i, funct3_i};
                ctrl_o.regwen  = 1'b1;
                ctrl_o.bsel    = 1'b0;
            end
            OPC_OP_IMM: begin
                // only SRAI carries alt; ADDI's imm[10] must not turn it into SUB
                ctrl_o.alu_sel = {1'b0, alt_bit_i & (funct3_i == 3'b101), funct3_i};
                ctrl_o.regwen  = 1'b1;
                ctrl_o.bsel    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the I, S, B, U and J formats.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] ins_i,
    input  imm_sel_e    sel_i,
    output logic [31:0] imm_o
);

    always_comb begin
        case (sel_i)
            IMM_I:   imm_o = {{20{ins_i[31]}}, ins_i[31:20]};
            IMM_S:   imm_o = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            IMM_B:   imm_o = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25],
                              ins_i[11:8], 1'b0};
            IMM_U:   imm_o = {ins_i[31:12], 12'd0};
            IMM_J:   imm_o = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20],
                              ins_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port; x0 is hardwired to zero.
module regfile
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] x [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                x[i] <= '0;
            end
        end else if (we_i && (rd_i != 5'd0)) begin
            x[rd_i] <= wd_i;
        end
    end

    assign rd1_o = (rs1_i == 5'd0) ? 32'd0 : x[rs1_i];
    assign rd2_o = (rs2_i == 5'd0) ? 32'd0 : x[rs2_i];

endmodule

// File: rtl/datapath.sv
// Single-cycle RV32IM execution core: fetch from the internal ROM, decode,
// read registers, execute and write back every clock.
module datapath
    import rv32_pkg::*;
(
    input logic clk,
    input logic rst
);

    logic [31:0] outPC;
    logic [31:0] pc_d;
    logic        PC_changed;
    logic [31:0] ins;
    ctrl_t       ctrl;
    logic [4:0]  ALUselect;
    logic        regwen;
    imm_sel_e    IMMselect;
    logic        bsel;
    logic [31:0] imm;
    logic [31:0] rs1_val, rs2_val, op_b;
    logic [31:0] ALUoutput;
    logic        unused_pc_changed;

    assign ins = rom_word(outPC[6:2]);

    control u_control (
        .opcode_i  (ins[6:0]),
        .funct3_i  (ins[14:12]),
        .m_bit_i   (ins[25]),
        .alt_bit_i (ins[30]),
        .ctrl_o    (ctrl)
    );

    assign ALUselect = ctrl.alu_sel;
    assign regwen    = ctrl.regwen;
    assign IMMselect = ctrl.imm_sel;
    assign bsel      = ctrl.bsel;

    imm_gen u_imm_gen (
        .ins_i (ins[31:7]),
        .sel_i (IMMselect),
        .imm_o (imm)
    );

    regfile registers (
        .clk   (clk),
        .rst   (rst),
        .we_i  (regwen),
        .rs1_i (ins[19:15]),
        .rs2_i (ins[24:20]),
        .rd_i  (ins[11:7]),
        .wd_i  (ALUoutput),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val)
    );

    assign op_b = bsel ? imm : rs2_val;

    alu u_alu (
        .a_i   (rs1_val),
        .b_i   (op_b),
        .sel_i (ALUselect),
        .y_o   (ALUoutput)
    );

    assign pc_d = (outPC + 32'd4) & PC_WRAP_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            outPC      <= 32'd0;
            PC_changed <= 1'b0;
        end else begin
            outPC      <= pc_d;
            PC_changed <= 1'b1;
        end
    end

    // PC_changed is observed hierarchically only
    assign unused_pc_changed = PC_changed;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: steps the built-in program and checks PC,
// decoded controls and register contents against hand-computed values.
module tb_datapath;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_x [32];

    always #5 clk = ~clk;

    datapath dut (
        .clk (clk),
        .rst (rst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_x%0d", tag, i), dut.registers.x[i], exp_x[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_x[i] = 32'd0;

        // reset held for two edges
        rst = 1'b1;
        step(2);
        chk("rst_pc", dut.outPC, 32'd0);
        chk("rst_pcchg", {31'd0, dut.PC_changed}, 32'd0);
        chk_regs("rst");
        chk("addi_ins", dut.ins, 32'h0050_0093);
        chk("addi_bsel", {31'd0, dut.bsel}, 32'd1);
        chk("addi_immsel", {29'd0, dut.IMMselect}, 32'd0);
        chk("addi_regwen", {31'd0, dut.regwen}, 32'd1);
        chk("addi_aluout", dut.ALUoutput, 32'd5);

        rst = 1'b0;
        step(1);
        chk("pc4", dut.outPC, 32'd4);
        chk("pcchg", {31'd0, dut.PC_changed}, 32'd1);
        chk("x1", dut.registers.x[1], 32'h0000_0005);
        chk("addi2_aluout", dut.ALUoutput, 32'hFFFF_FFFD);
        step(1);
        chk("pc8", dut.outPC, 32'd8);
        chk("x2", dut.registers.x[2], 32'hFFFF_FFFD);
        chk("add_alusel", {27'd0, dut.ALUselect}, 32'h00);
        chk("add_bsel", {31'd0, dut.bsel}, 32'd0);
        step(1);
        chk("x3", dut.registers.x[3], 32'h0000_0002);
        chk("mul_alusel", {27'd0, dut.ALUselect}, 32'h10);
        step(1);
        chk("x4", dut.registers.x[4], 32'hFFFF_FFF1);
        step(1);
        chk("x5", dut.registers.x[5], 32'hFFFF_FFFF);
        chk("srai_alusel", {27'd0, dut.ALUselect}, 32'h0D);
        chk("srai_bsel", {31'd0, dut.bsel}, 32'd1);
        step(1);
        chk("x6", dut.registers.x[6], 32'hFFFF_FFFE);
        step(1);
        chk("x0", dut.registers.x[0], 32'd0);
        chk("pc28", dut.outPC, 32'd28);
        chk("bad_regwen", {31'd0, dut.regwen}, 32'd0);
        chk("bad_bsel", {31'd0, dut.bsel}, 32'd0);
        chk("bad_alusel", {27'd0, dut.ALUselect}, 32'd0);
        step(1);
        chk("pc32", dut.outPC, 32'd32);
        exp_x[1] = 32'h0000_0005;
        exp_x[2] = 32'hFFFF_FFFD;
        exp_x[3] = 32'h0000_0002;
        exp_x[4] = 32'hFFFF_FFF1;
        exp_x[5] = 32'hFFFF_FFFF;
        exp_x[6] = 32'hFFFF_FFFE;
        chk_regs("p8");

        // rest of the ROM, then PC wraps to 0
        step(24);
        chk("pc_wrap", dut.outPC, 32'd0);
        exp_x[7]  = 32'h0000_0008;
        exp_x[8]  = 32'hFFFF_FFFF;
        exp_x[9]  = 32'h0000_0004;
        exp_x[10] = 32'h0000_0000;
        exp_x[11] = 32'hFFFF_FFFD;
        exp_x[12] = 32'h3333_3332;
        exp_x[13] = 32'h0000_0001;
        exp_x[14] = 32'h0000_0000;
        exp_x[15] = 32'h0000_000F;
        exp_x[16] = 32'h0000_0050;
        exp_x[17] = 32'hFFFF_FFFA;
        exp_x[18] = 32'hFFFF_FFFF;
        exp_x[19] = 32'h0000_0005;
        exp_x[20] = 32'h0000_0000;
        exp_x[21] = 32'h0000_0005;
        exp_x[22] = 32'hFFFF_FFFD;
        exp_x[23] = 32'hA000_0000;
        exp_x[24] = 32'hFFFF_FFFF;
        exp_x[25] = 32'h8000_0000;
        exp_x[26] = 32'h8000_0000;
        exp_x[27] = 32'hFFFF_FFFF;
        exp_x[28] = 32'h0000_0000;
        chk_regs("full");

        // mid-program reset restarts cleanly
        step(3);
        chk("pc12", dut.outPC, 32'd12);
        rst = 1'b1;
        step(1);
        chk("mrst_pc", dut.outPC, 32'd0);
        chk("mrst_pcchg", {31'd0, dut.PC_changed}, 32'd0);
        chk("mrst_x1", dut.registers.x[1], 32'd0);
        chk("mrst_x26", dut.registers.x[26], 32'd0);
        rst = 1'b0;
        step(1);
        chk("mrel_pc", dut.outPC, 32'd4);
        chk("mrel_pcchg", {31'd0, dut.PC_changed}, 32'd1);
        chk("mrel_x1", dut.registers.x[1], 32'h0000_0005);
        chk("mrel_x2", dut.registers.x[2], 32'd0);
        step(1);
        chk("mrel2_x2", dut.registers.x[2], 32'hFFFF_FFFD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
